// File: rtl/noc_pkg.sv
// rtl/noc_pkg.sv - shared flit-type, port-index and mesh constants for the router input stage
package noc_pkg;

    localparam logic [1:0] FT_BODY    = 2'b00;
    localparam logic [1:0] FT_TAIL    = 2'b01;
    localparam logic [1:0] FT_HDR     = 2'b10;
    localparam logic [1:0] FT_HDRTAIL = 2'b11;

    localparam int PORT_L     = 0;
    localparam int PORT_E     = 1;
    localparam int PORT_W     = 2;
    localparam int PORT_S     = 3;
    localparam int PORT_N     = 4;
    localparam int PORT_NUM   = 5;
    localparam int PORT_IDX_W = 3;

    localparam int X_NODE_NUM = 4;
    localparam int Y_NODE_NUM = 4;
    localparam int X_COORD_W  = 2;
    localparam int Y_COORD_W  = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_XFER = 2'd2,
        ST_DROP = 2'd3
    } ibuf_state_e;

    // Bit 1 marks a header, bit 0 marks a tail; HDR+TAIL carries both.
    function automatic logic is_hdr(input logic [1:0] t);
        return t[1];
    endfunction

    function automatic logic is_tail(input logic [1:0] t);
        return t[0];
    endfunction

endpackage

// File: rtl/ibuf_fifo.sv
// rtl/ibuf_fifo.sv - circular flit buffer with push/pop and occupancy count
module ibuf_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 10
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [WIDTH-1:0]         i_data,
    output logic [WIDTH-1:0]         o_head,
    output logic                     o_empty,
    output logic                     o_full,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    assign w_push = i_push && !o_full;
    assign w_pop  = i_pop && !o_empty;

    // Pointers wrap by natural overflow since DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_data;
    end

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_head  = o_empty ? '0 : r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/input_port_buffer.sv
// rtl/input_port_buffer.sv - input flit FIFO with wormhole route lock; IBUF_ERR_CHECK_EN adds err_flag
module input_port_buffer
    import noc_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int FLIT_W = 8,
    parameter int NPORT  = 5
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [FLIT_W-1:0]       in_flit,
    input  logic [1:0]              in_type,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [3:0]              rc_dest,
    input  logic [NPORT-1:0]        rc_req,
    output logic [NPORT-1:0]        sa_req,
    input  logic                    sa_grant,
    output logic [FLIT_W-1:0]       out_flit,
    output logic [1:0]              out_type,
    output logic                    out_valid,
    output logic [$clog2(DEPTH):0]  fifo_count
`ifdef IBUF_ERR_CHECK_EN
    ,
    output logic                    err_flag
`endif
);

    ibuf_state_e        r_state;
    logic [NPORT-1:0]   r_route_q;
    logic [FLIT_W+1:0]  w_head;
    logic [1:0]         w_head_type;
    logic               w_empty;
    logic               w_full;
    logic               w_push;
    logic               w_pop;
    logic               w_fwd_pop;

    ibuf_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (FLIT_W + 2)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  ({in_type, in_flit}),
        .o_head  (w_head),
        .o_empty (w_empty),
        .o_full  (w_full),
        .o_count (fifo_count)
    );

    assign w_head_type = w_head[FLIT_W+1:FLIT_W];
    assign in_ready    = !w_full;
    assign w_push      = in_valid && !w_full;
    assign out_valid   = ((r_state == ST_REQ) || (r_state == ST_XFER)) && !w_empty;
    assign w_fwd_pop   = out_valid && sa_grant;
    assign sa_req      = r_route_q;
    assign rc_dest     = w_head[3:0];
    assign out_flit    = w_head[FLIT_W-1:0];
    assign out_type    = w_head_type;

`ifdef IBUF_ERR_CHECK_EN
    logic r_err;
    logic w_discard;

    // Stray non-headers, unroutable headers and the rest of a dropped packet are popped internally.
    assign w_discard = !w_empty &&
                       (((r_state == ST_IDLE) && (!is_hdr(w_head_type) || (rc_req == '0))) ||
                        (r_state == ST_DROP));
    assign w_pop     = w_fwd_pop || w_discard;
    assign err_flag  = r_err;
`else
    assign w_pop     = w_fwd_pop;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_route_q <= '0;
`ifdef IBUF_ERR_CHECK_EN
            r_err     <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!w_empty) begin
`ifdef IBUF_ERR_CHECK_EN
                        if (!is_hdr(w_head_type)) begin
                            r_err <= 1'b1;
                        end else if (rc_req == '0) begin
                            r_err <= 1'b1;
                            if (!is_tail(w_head_type)) r_state <= ST_DROP;
                        end else begin
                            r_route_q <= rc_req;
                            r_state   <= ST_REQ;
                        end
`else
                        r_route_q <= (rc_req == '0) ? NPORT'(1) : rc_req;
                        r_state   <= ST_REQ;
`endif
                    end
                end
                ST_REQ, ST_XFER: begin
                    if (w_fwd_pop) begin
                        if (is_tail(w_head_type)) begin
                            r_state   <= ST_IDLE;
                            r_route_q <= '0;
                        end else begin
                            r_state   <= ST_XFER;
                        end
                    end
                end
`ifdef IBUF_ERR_CHECK_EN
                ST_DROP: begin
                    if (w_discard && is_tail(w_head_type)) r_state <= ST_IDLE;
                end
`endif
                default: begin
                    r_state   <= ST_IDLE;
                    r_route_q <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_input_port_buffer.sv
// tb/tb_input_port_buffer.sv - scoreboard bench for input_port_buffer
module tb_input_port_buffer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] in_flit;
    logic [1:0] in_type;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] rc_dest;
    logic [4:0] rc_req;
    logic [4:0] sa_req;
    logic       sa_grant;
    logic [7:0] out_flit;
    logic [1:0] out_type;
    logic       out_valid;
    logic [2:0] fifo_count;
`ifdef IBUF_ERR_CHECK_EN
    logic       err_flag;
`endif

    int checks = 0;
    int errors = 0;
    int pops   = 0;
    logic [9:0] exp_q[$];

    input_port_buffer #(.DEPTH(4), .FLIT_W(8), .NPORT(5)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_flit    (in_flit),
        .in_type    (in_type),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .rc_dest    (rc_dest),
        .rc_req     (rc_req),
        .sa_req     (sa_req),
        .sa_grant   (sa_grant),
        .out_flit   (out_flit),
        .out_type   (out_type),
        .out_valid  (out_valid),
        .fifo_count (fifo_count)
`ifdef IBUF_ERR_CHECK_EN
        ,
        .err_flag   (err_flag)
`endif
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && sa_grant) begin
                logic [9:0] e;
                checks++;
                pops++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL pop_order: got %h expected nothing", {out_type, out_flit});
                end else begin
                    e = exp_q.pop_front();
                    if ({out_type, out_flit} !== e) begin
                        errors++;
                        $display("FAIL pop_order: got %h expected %h", {out_type, out_flit}, e);
                    end
                end
            end
            if (in_valid && in_ready) exp_q.push_back({in_type, in_flit});
        end
    end

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] t, input logic [7:0] f);
        in_valid = v;
        in_type  = t;
        in_flit  = f;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (sa_req !== 5'b0 && n < 12) begin
            next();
            n++;
        end
        checks++;
        if (sa_req !== 5'b0) begin
            errors++;
            $display("FAIL %s_timeout: sa_req %b expected 00000", name, sa_req);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; sa_grant = 1'b0; rc_req = '0;
        drive(1'b0, 2'b00, 8'h00);
        next(); next();
        checks++;
        if ({in_ready, out_valid, sa_req, fifo_count, rc_dest, out_flit} !== {1'b1, 1'b0, 5'b0, 3'd0, 4'h0, 8'h00}) begin
            errors++;
            $display("FAIL reset_state: rdy %b vld %b req %b cnt %0d dest %h flit %h", in_ready, out_valid, sa_req, fifo_count, rc_dest, out_flit);
        end
`ifdef IBUF_ERR_CHECK_EN
        checks++;
        if (err_flag !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err_flag); end
`endif
        rst_n = 1'b1;
        next();
    endtask

    task automatic test_single();
        rc_req = 5'b00010;
        drive(1'b1, 2'b11, 8'h0B);
        next();
        drive(1'b0, 2'b00, 8'h00);
        checks++;
        if (sa_req !== 5'b0 || rc_dest !== 4'hB || fifo_count !== 3'd1) begin
            errors++;
            $display("FAIL single_n1: req %b dest %h cnt %0d expected 00000 b 1", sa_req, rc_dest, fifo_count);
        end
        next();
        checks++;
        if (sa_req !== 5'b00010 || out_valid !== 1'b1 || out_flit !== 8'h0B) begin
            errors++;
            $display("FAIL single_n2: req %b vld %b flit %h expected 00010 1 0b", sa_req, out_valid, out_flit);
        end
        next();
        sa_grant = 1'b1;
        checks++;
        if (sa_req !== 5'b00010) begin errors++; $display("FAIL single_n3: req %b expected 00010", sa_req); end
        next();
        sa_grant = 1'b0;
        checks++;
        if (sa_req !== 5'b0 || fifo_count !== 3'd0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_done: req %b cnt %0d vld %b expected 00000 0 0", sa_req, fifo_count, out_valid);
        end
    endtask

    task automatic test_packet4();
        logic [9:0] flits[4];
        int p0;
        flits[0] = {2'b10, 8'h06}; flits[1] = {2'b00, 8'h11};
        flits[2] = {2'b00, 8'h22}; flits[3] = {2'b01, 8'h33};
        p0 = pops;
        rc_req = 5'b00001; sa_grant = 1'b1;
        drive(1'b1, flits[0][9:8], flits[0][7:0]);
        for (int k = 1; k <= 6; k++) begin
            logic [4:0] er;
            next();
            er = (k >= 2 && k <= 5) ? 5'b00001 : 5'b00000;
            checks++;
            if (sa_req !== er) begin errors++; $display("FAIL pkt4_req_c%0d: got %b expected %b", k, sa_req, er); end
            if (k < 4) drive(1'b1, flits[k][9:8], flits[k][7:0]);
            else drive(1'b0, 2'b00, 8'h00);
        end
        sa_grant = 1'b0;
        checks++;
        if (pops - p0 !== 4 || fifo_count !== 3'd0) begin
            errors++;
            $display("FAIL pkt4_pops: pops %0d cnt %0d expected 4 0", pops - p0, fifo_count);
        end
    endtask

    task automatic test_fill_wrap();
        int p0;
        p0 = pops;
        rc_req = 5'b00100; sa_grant = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, (i == 0) ? 2'b10 : 2'b00, 8'h40 + 8'(i));
            next();
        end
        checks++;
        if (in_ready !== 1'b0 || fifo_count !== 3'd4 || sa_req !== 5'b00100 || out_flit !== 8'h40) begin
            errors++;
            $display("FAIL fill_full: rdy %b cnt %0d req %b flit %h expected 0 4 00100 40", in_ready, fifo_count, sa_req, out_flit);
        end
        drive(1'b1, 2'b00, 8'h44);
        sa_grant = 1'b1;
        next();
        checks++;
        if (fifo_count !== 3'd3 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL fill_first_pop: cnt %0d rdy %b expected 3 1", fifo_count, in_ready);
        end
        for (int j = 1; j <= 4; j++) begin
            next();
            checks++;
            if (fifo_count !== 3'd3) begin errors++; $display("FAIL fill_pushpop_%0d: cnt %0d expected 3", j, fifo_count); end
            if (j < 3) drive(1'b1, 2'b00, 8'h44 + 8'(j));
            else if (j == 3) drive(1'b1, 2'b01, 8'h47);
            else drive(1'b0, 2'b00, 8'h00);
        end
        wait_idle("fill");
        sa_grant = 1'b0;
        checks++;
        if (pops - p0 !== 8 || fifo_count !== 3'd0) begin
            errors++;
            $display("FAIL fill_drain: pops %0d cnt %0d expected 8 0", pops - p0, fifo_count);
        end
    endtask

    task automatic test_stall();
        rc_req = 5'b01000; sa_grant = 1'b1;
        drive(1'b1, 2'b10, 8'h50);
        next();
        drive(1'b1, 2'b00, 8'h51);
        next();
        drive(1'b0, 2'b00, 8'h00);
        next(); next(); next();
        checks++;
        if (out_valid !== 1'b0 || sa_req !== 5'b01000 || fifo_count !== 3'd0) begin
            errors++;
            $display("FAIL stall_empty: vld %b req %b cnt %0d expected 0 01000 0", out_valid, sa_req, fifo_count);
        end
        rc_req = 5'b00010;
        next();
        drive(1'b1, 2'b00, 8'h52);
        next();
        drive(1'b0, 2'b00, 8'h00);
        checks++;
        if (out_valid !== 1'b1 || sa_req !== 5'b01000 || out_flit !== 8'h52) begin
            errors++;
            $display("FAIL stall_resume: vld %b req %b flit %h expected 1 01000 52", out_valid, sa_req, out_flit);
        end
        next();
        drive(1'b1, 2'b01, 8'h53);
        next();
        drive(1'b0, 2'b00, 8'h00);
        wait_idle("stall");
        sa_grant = 1'b0;
    endtask

    task automatic test_reset_mid();
        rc_req = 5'b10000; sa_grant = 1'b0;
        drive(1'b1, 2'b10, 8'h60); next();
        drive(1'b1, 2'b00, 8'h61); next();
        drive(1'b1, 2'b00, 8'h62); next();
        drive(1'b0, 2'b00, 8'h00); next();
        checks++;
        if (fifo_count !== 3'd3 || sa_req !== 5'b10000) begin
            errors++;
            $display("FAIL rstmid_pre: cnt %0d req %b expected 3 10000", fifo_count, sa_req);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (sa_req !== 5'b0 || out_valid !== 1'b0 || in_ready !== 1'b1 || fifo_count !== 3'd0) begin
            errors++;
            $display("FAIL rstmid_now: req %b vld %b rdy %b cnt %0d expected 00000 0 1 0", sa_req, out_valid, in_ready, fifo_count);
        end
        exp_q.delete();
        next();
        rst_n = 1'b1;
        next();
    endtask

    task automatic test_stray_body();
        rc_req = 5'b00010; sa_grant = 1'b0;
        drive(1'b1, 2'b00, 8'h70);
        next();
        drive(1'b0, 2'b00, 8'h00);
`ifdef IBUF_ERR_CHECK_EN
        for (int c = 0; c < 3; c++) begin
            next();
            checks++;
            if (sa_req !== 5'b0 || fifo_count !== 3'd0 || err_flag !== 1'b1) begin
                errors++;
                $display("FAIL stray_discard_c%0d: req %b cnt %0d err %b expected 00000 0 1", c, sa_req, fifo_count, err_flag);
            end
        end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
`else
        next();
        checks++;
        if (sa_req !== 5'b00010 || out_valid !== 1'b1 || out_flit !== 8'h70) begin
            errors++;
            $display("FAIL stray_routed: req %b vld %b flit %h expected 00010 1 70", sa_req, out_valid, out_flit);
        end
        sa_grant = 1'b1;
        next();
        drive(1'b1, 2'b01, 8'h71);
        next();
        drive(1'b0, 2'b00, 8'h00);
        wait_idle("stray");
        sa_grant = 1'b0;
`endif
    endtask

    initial begin
        test_reset();
        test_single();
        test_packet4();
        test_fill_wrap();
        test_stall();
        test_reset_mid();
        test_stray_body();
        next();
        checks++;
        if (exp_q.size() != 0 || fifo_count !== 3'd0) begin
            errors++;
            $display("FAIL final_empty: queue %0d cnt %0d expected 0 0", exp_q.size(), fifo_count);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
